// File: rtl/event_counter_multi.sv
// Push-button event counter. It counts debounced KEY[0] presses while SW lies in
// [WIN_LO, WIN_HI]. KEY[1] clears the count. HEX shows the count as hex digits.
module event_counter_multi #(
    parameter int SW_W      = 10,
    parameter int CNT_W     = 10,
    parameter int WIN_LO    = 9,
    parameter int WIN_HI    = 12,
    parameter int SAT_MODE  = 0,
    parameter int DB_CYCLES = 16,
    parameter int DIGITS    = 3
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic [1:0]            KEY,
    input  logic [SW_W-1:0]       SW,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  in_window,
    output logic [7*DIGITS-1:0]   HEX,
    output logic [SW_W-1:0]       LEDR
);

    localparam int               DB_W     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [SW_W-1:0]  LO       = SW_W'(WIN_LO);
    localparam logic [SW_W-1:0]  HI       = SW_W'(WIN_HI);
    localparam int               HEX_BITS = 4 * DIGITS;

    logic [1:0]      key_meta, key_sync;
    logic [1:0]      db_level, db_prev, press;
    logic [DB_W-1:0] db_cnt [2];
    logic [SW_W-1:0] sw_meta, sw_sync;
    logic [HEX_BITS-1:0] cnt_ext;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_meta <= 2'b11;
            key_sync <= 2'b11;
            sw_meta  <= '0;
            sw_sync  <= '0;
        end else begin
            key_meta <= KEY;
            key_sync <= key_meta;
            sw_meta  <= SW;
            sw_sync  <= sw_meta;
        end
    end

    // Levels restart at "released", so a key held through reset needs a fresh debounced edge
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            db_cnt[0] <= '0;
            db_cnt[1] <= '0;
            db_level  <= 2'b11;
            db_prev   <= 2'b11;
        end else begin
            db_prev <= db_level;
            for (int k = 0; k < 2; k++) begin
                if (key_sync[k] == db_level[k]) begin
                    db_cnt[k] <= '0;
                end else if (db_cnt[k] == DB_LAST) begin
                    db_level[k] <= key_sync[k];
                    db_cnt[k]   <= '0;
                end else begin
                    db_cnt[k] <= db_cnt[k] + 1'b1;
                end
            end
        end
    end

    assign press = db_prev & ~db_level;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            in_window <= 1'b0;
            LEDR      <= '0;
        end else begin
            in_window <= (sw_sync >= LO) && (sw_sync <= HI);
            LEDR      <= sw_sync;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (press[1]) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (press[0] && in_window) begin
            if (count == CNT_MAX) begin
                count    <= (SAT_MODE != 0) ? CNT_MAX : '0;
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        s = 7'b1000000;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            4'hF: s = 7'b0001110;
            default: s = 7'b1000000;
        endcase
        return s;
    endfunction

    assign cnt_ext = HEX_BITS'(count);

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign HEX[7*i +: 7] = seg7(cnt_ext[4*i +: 4]);
    end

endmodule

// File: tb/tb_event_counter_multi.sv
// Bench for event_counter_multi. It drives four instances: the default build, a
// 4-bit wrap build, a 4-bit saturate build and a fast 4-digit build with DB_CYCLES=1.
module tb_event_counter_multi;

    logic CLOCK_50 = 1'b0;
    logic reset;
    logic [1:0] key_v [4];
    logic [9:0] sw_v  [4];

    always #5 CLOCK_50 = ~CLOCK_50;

    logic [9:0]  cnt0, led0;
    logic        ovf0, inw0;
    logic [20:0] hex0;
    logic [3:0]  cnt1, cnt2;
    logic        ovf1, inw1, ovf2, inw2;
    logic [6:0]  hex1, hex2;
    logic [9:0]  led1, led2, led3;
    logic [9:0]  cnt3;
    logic        ovf3, inw3;
    logic [27:0] hex3;

    event_counter_multi u0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(key_v[0]), .SW(sw_v[0]),
        .count(cnt0), .overflow(ovf0), .in_window(inw0), .HEX(hex0), .LEDR(led0));

    event_counter_multi #(.CNT_W(4), .SAT_MODE(0), .DIGITS(1)) u1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(key_v[1]), .SW(sw_v[1]),
        .count(cnt1), .overflow(ovf1), .in_window(inw1), .HEX(hex1), .LEDR(led1));

    event_counter_multi #(.CNT_W(4), .SAT_MODE(1), .DIGITS(1)) u2 (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(key_v[2]), .SW(sw_v[2]),
        .count(cnt2), .overflow(ovf2), .in_window(inw2), .HEX(hex2), .LEDR(led2));

    event_counter_multi #(.DB_CYCLES(1), .DIGITS(4)) u3 (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(key_v[3]), .SW(sw_v[3]),
        .count(cnt3), .overflow(ovf3), .in_window(inw3), .HEX(hex3), .LEDR(led3));

    int n_cmp = 0;
    int n_bad = 0;

    logic [6:0] font [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [9:0] sw;
        logic       exp_inwin;
        logic [9:0] exp_count;
    } win_vec_t;

    win_vec_t win_tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    // mask selects which KEY bits go low together; each phase lasts `hold` cycles
    task automatic press(input int inst, input logic [1:0] mask, input int hold);
        key_v[inst] = ~mask;
        step(hold);
        key_v[inst] = 2'b11;
        step(hold);
    endtask

    function automatic logic [27:0] exp_hex(input logic [15:0] v);
        logic [27:0] r;
        for (int i = 0; i < 4; i++) r[7*i +: 7] = font[v[4*i +: 4]];
        return r;
    endfunction

    function automatic bit in_win(input logic [9:0] s);
        return (s >= 10'd9) && (s <= 10'd12);
    endfunction

    logic [27:0] eh;
    logic [9:0]  m;
    logic        movf;
    logic [9:0]  sw;

    initial begin
        win_tbl[0] = '{10'd8,    1'b0, 10'd0};
        win_tbl[1] = '{10'd9,    1'b1, 10'd1};
        win_tbl[2] = '{10'd12,   1'b1, 10'd2};
        win_tbl[3] = '{10'd13,   1'b0, 10'd2};
        win_tbl[4] = '{10'd0,    1'b0, 10'd2};
        win_tbl[5] = '{10'd1023, 1'b0, 10'd2};
        win_tbl[6] = '{10'd10,   1'b1, 10'd3};
        win_tbl[7] = '{10'd11,   1'b1, 10'd4};

        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            key_v[i] = 2'b11;
            sw_v[i]  = 10'h3FF;
        end
        #23;
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_ovf", 32'(ovf0), 32'd0);
        check("rst_inwin", 32'(inw0), 32'd0);
        check("rst_ledr", 32'(led0), 32'd0);
        check("rst_hex", 32'(hex0), 32'({3{7'b1000000}}));
        check("rst_hex_u3", 32'(hex3), 32'({4{7'b1000000}}));

        for (int i = 0; i < 4; i++) sw_v[i] = 10'd10;
        @(posedge CLOCK_50);
        #1 reset = 1'b0;
        step(4);

        // window bounds, table-driven
        for (int v = 0; v < 8; v++) begin
            sw_v[0] = win_tbl[v].sw;
            step(4);
            check($sformatf("win_inwin[%0d]", v), 32'(inw0), 32'(win_tbl[v].exp_inwin));
            check($sformatf("win_ledr[%0d]", v), 32'(led0), 32'(win_tbl[v].sw));
            press(0, 2'b01, 22);
            check($sformatf("win_count[%0d]", v), 32'(cnt0), 32'(win_tbl[v].exp_count));
        end

        // bounce then hold: five toggles three cycles apart, last one held low
        sw_v[0] = 10'd10;
        step(4);
        for (int t = 0; t < 5; t++) begin
            key_v[0][0] = ~key_v[0][0];
            if (t < 4) step(3);
        end
        repeat (18) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("lat_before", 32'(cnt0), 32'd4);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("lat_at19", 32'(cnt0), 32'd5);
        step(30);
        key_v[0] = 2'b11;
        step(25);
        check("lat_single", 32'(cnt0), 32'd5);

        // simultaneous count and clear with count = 5
        press(0, 2'b11, 22);
        check("simul_count", 32'(cnt0), 32'd0);
        step(30);
        check("simul_after", 32'(cnt0), 32'd0);
        check("simul_ovf", 32'(ovf0), 32'd0);

        // randomized operations against a plain arithmetic model
        m = 10'd0;
        movf = 1'b0;
        for (int op = 0; op < 40; op++) begin
            sw = ($urandom_range(0, 3) == 0) ? 10'($urandom) : 10'($urandom_range(6, 15));
            sw_v[0] = sw;
            step(4);
            check("rnd_inwin", 32'(inw0), 32'(in_win(sw)));
            check("rnd_ledr", 32'(led0), 32'(sw));
            if ($urandom_range(0, 2) == 0) begin
                key_v[0] = 2'b10;
                step($urandom_range(1, 12));
                key_v[0] = 2'b11;
                step(4);
                check("rnd_glitch", 32'(cnt0), 32'(m));
            end
            if ($urandom_range(0, 9) == 0) begin
                press(0, 2'b10, 22);
                m = 10'd0;
                movf = 1'b0;
            end else begin
                press(0, 2'b01, 22);
                if (in_win(sw)) begin
                    if (m == 10'd1023) movf = 1'b1;
                    m = m + 10'd1;
                end
            end
            check("rnd_count", 32'(cnt0), 32'(m));
            check("rnd_ovf", 32'(ovf0), 32'(movf));
            eh = exp_hex(16'(m));
            check("rnd_hex", 32'(hex0), 32'(eh[20:0]));
        end

        // wrap build: 16 presses
        for (int p = 1; p <= 15; p++) begin
            press(1, 2'b01, 22);
            check($sformatf("wrap_count[%0d]", p), 32'(cnt1), 32'(p));
        end
        check("wrap_ovf_pre", 32'(ovf1), 32'd0);
        press(1, 2'b01, 22);
        check("wrap_count16", 32'(cnt1), 32'd0);
        check("wrap_ovf", 32'(ovf1), 32'd1);
        check("wrap_hex", 32'(hex1), 32'(7'b1000000));

        // saturate build: 17 presses then clear
        for (int p = 1; p <= 17; p++) press(2, 2'b01, 22);
        check("sat_count", 32'(cnt2), 32'd15);
        check("sat_ovf", 32'(ovf2), 32'd1);
        check("sat_hex", 32'(hex2), 32'(7'b0001110));
        press(2, 2'b10, 22);
        check("sat_clr_count", 32'(cnt2), 32'd0);
        check("sat_clr_ovf", 32'(ovf2), 32'd0);

        // fast build: drive count to 0x1A3 and read the digits
        for (int p = 0; p < 419; p++) press(3, 2'b01, 6);
        check("hex_count", 32'(cnt3), 32'h1A3);
        check("hex_digits", 32'(hex3), 32'({7'b1000000, 7'b1111001, 7'b0001000, 7'b0110000}));

        // reset in the middle of a debounce, released with the key still low
        sw_v[0] = 10'd10;
        press(0, 2'b01, 22);
        key_v[0] = 2'b10;
        step(8);
        reset = 1'b1;
        #1;
        check("rst_async_count", 32'(cnt0), 32'd0);
        step(3);
        reset = 1'b0;
        step(5);
        check("rst_held_count", 32'(cnt0), 32'd0);
        key_v[0] = 2'b11;
        step(25);
        check("rst_release_count", 32'(cnt0), 32'd0);
        press(0, 2'b01, 22);
        check("rst_repress_count", 32'(cnt0), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/event_counter_multi.md
Name: event_counter_multi

Overview:
- Parametrised successor to the board-level push-button event counter.
- Counts debounced button presses only while the switch value lies inside a configurable window [WIN_LO, WIN_HI].
- Count width, wrap or saturate mode, debounce time and the number of 7-segment digits are all parametrised.
- Fully synchronous to CLOCK_50, with no derived clocks. Sits at the top level between the board KEY/SW/HEX/LEDR pins.

Parameters:
- SW_W, 10, switch bus width.
- CNT_W, 10, counter width (1..16).
- WIN_LO, 9, inclusive lower bound of the count window (unsigned, compared against SW).
- WIN_HI, 12, inclusive upper bound of the count window; WIN_LO <= WIN_HI required.
- SAT_MODE, 0, 0 = wrap to 0 after the maximum value, 1 = saturate at 2^CNT_W-1.
- DB_CYCLES, 16, number of consecutive stable synchronised samples needed to accept a key level change (>= 1).
- DIGITS, 3, number of hex digits driven (1..4).

Ports:
- CLOCK_50, input, 1, system clock.
- reset, input, 1, asynchronous, active-high; clock CLOCK_50.
- KEY, input, 2, raw active-low buttons: KEY[0] = count, KEY[1] = clear.
- SW, input, SW_W, raw switches.
- count, output, CNT_W, current count value.
- overflow, output, 1, sticky flag: an increment was attempted at 2^CNT_W-1.
- in_window, output, 1, registered window-compare result.
- HEX, output, 7*DIGITS, active-low segments; digit i occupies bits [7i+6:7i].
- LEDR, output, SW_W, registered copy of the synchronised SW value.

Behaviour:
- Reset (async assert, sync release):
  - count=0, overflow=0, in_window=0, LEDR=0.
  - Synchronisers=all 1 (keys released), SW synchroniser=0, debounce counters=0, debounced levels=1.
  - HEX shows all digits "0" (7'b1000000 each).
- Synchronisation: KEY and SW each pass through a 2-FF synchroniser. in_window <= (sw_s >= WIN_LO) && (sw_s <= WIN_HI), unsigned. LEDR <= sw_s.
- Debounce, per key, independent:
  - While sync level == debounced level, the debounce counter is held at 0.
  - Otherwise the counter increments each cycle. When it reaches DB_CYCLES-1 with the mismatch still present, the debounced level takes the sync level and the counter returns to 0.
  - Any sample equal to the debounced level before that point clears the counter (glitch rejected).
- Press pulse: a 1-cycle strobe issued on the cycle the debounced level goes 1->0. Release generates nothing.
- Counter update, on the edge after a strobe, in priority order:
  - clear strobe -> count=0, overflow=0. Clear wins over a simultaneous count strobe.
  - count strobe and in_window=0 -> no change.
  - count strobe, in_window=1, count < max -> count+1.
  - count strobe, in_window=1, count == max:
    - SAT_MODE=0 -> count=0, overflow=1.
    - SAT_MODE=1 -> count held at max, overflow=1.
- in_window is sampled in the same cycle as the count strobe.
- Latency: a clean KEY[0] falling edge updates count exactly 2 (sync) + DB_CYCLES + 1 cycles later.
- HEX is combinational from count:
  - Digit i decodes count bits [4i+3:4i], zero-extended beyond CNT_W.
  - Standard active-low hex font 0-F.
- A reset asserted mid-debounce or mid-count aborts all state immediately. No strobe is issued on reset release even if KEY is held low; a held key counts only after a fresh debounced edge, i.e. after DB_CYCLES stable low samples from the released state.

Test Plan:
- Window bounds: SW=8, 9, 12, 13, one clean press each -> count increments only for 9 and 12; final count=2; in_window matches each value.
- Latency and bounce: with DB_CYCLES=16, KEY[0] toggled 5 times at 3-cycle intervals, then held low -> exactly one increment, 19 cycles after the final falling edge.
- Wrap: CNT_W=4, SAT_MODE=0, SW=10, 16 presses -> count 15 then 0, overflow=1, HEX0=7'b1000000.
- Saturate: CNT_W=4, SAT_MODE=1, 17 presses -> count=15 held, overflow=1. Then a clear press -> count=0, overflow=0.
- Simultaneous strobes: KEY[0] and KEY[1] pressed on the same cycle with count=5 -> count=0, no increment afterwards.
- Reset mid-operation: reset asserted while KEY[0] is low mid-debounce, released with KEY[0] still low -> count stays 0. Release and re-press -> count=1. HEX for count=0x1A3 is 7'b0110000, 7'b0001000, 7'b1111001 (digit0..2).
